// File: rtl/dmem_pkg.sv
// Shared constants and types for the MEM-stage data memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_ILLEGAL  = 2'b11
    } fault_cause_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    // Access width in bytes; 0 marks an encoding with no defined width.
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            F3_W:        access_bytes = 3'd4;
            default:     access_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [2:0]   f3;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         resp_valid;
    logic [31:0]  rdata;
    logic         fault;
    fault_cause_t fault_cause;

    modport master (
        output req_valid, req_write, f3, addr, wdata,
        input  req_ready, resp_valid, rdata, fault, fault_cause
    );

    modport slave (
        input  req_valid, req_write, f3, addr, wdata,
        output req_ready, resp_valid, rdata, fault, fault_cause
    );
endinterface

// File: rtl/dmem_word_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
module dmem_word_ram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           Clock,
    input  logic                           en,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // be[k] guards bits [8k+7:8k]; rdata returns the pre-write contents.
    always_ff @(posedge Clock) begin
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Big-endian RV32 load/store controller with fault checks and optional two-beat
// handling of accesses that straddle a word boundary.
module dmem_ctrl import dmem_pkg::*; #(
    parameter int DEPTH_WORDS    = 256,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic  Clock,
    input  logic  nReset,
    dmem_if.slave bus
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);

    state_t       state;
    logic         respValid, faultReg;
    fault_cause_t faultCause;
    logic         respLoad, respSigned, respSplit;
    logic [1:0]   respOff;
    logic [2:0]   respBytes;
    logic [31:0]  beat1Word;
    logic [IDX_W-1:0] pendIdx;
    logic [3:0]   pendBe;
    logic [31:0]  pendData;

    logic         accept, illegal, outOfRange, misaligned, crossing;
    logic [2:0]   nBytes;
    logic [1:0]   off;
    logic [IDX_W-1:0] reqIdx;
    fault_cause_t cause;
    logic [31:0]  wordAligned;
    logic [3:0]   laneMask;
    logic [63:0]  wdata64;
    logic [7:0]   be8;

    logic         ramEn;
    logic [3:0]   ramBe;
    logic [IDX_W-1:0] ramIdx;
    logic [31:0]  ramWdata, ramRdata;

    logic [63:0]  merged;
    logic [31:0]  sel, loadVal;

    assign bus.req_ready   = (state == S_IDLE);
    assign accept          = bus.req_valid && bus.req_ready;
    assign bus.resp_valid  = respValid;
    assign bus.fault       = faultReg;
    assign bus.fault_cause = faultCause;

    // The two words an access may touch are treated as one 64-bit big-endian window.
    always_comb begin
        nBytes     = access_bytes(bus.f3);
        off        = bus.addr[1:0];
        reqIdx     = bus.addr[IDX_W+1:2];
        illegal    = (nBytes == 3'd0) || (bus.req_write && bus.f3[2]);
        outOfRange = ({1'b0, bus.addr} + {30'd0, nBytes} - 33'd1) >= MEM_BYTES;
        misaligned = ((nBytes == 3'd2) && off[0]) || ((nBytes == 3'd4) && (off != 2'b00));
        crossing   = ({1'b0, off} + nBytes) > 3'd4;

        if (illegal)                            cause = FC_ILLEGAL;
        else if (outOfRange)                    cause = FC_RANGE;
        else if (misaligned && !MISALIGN_SPLIT) cause = FC_MISALIGN;
        else                                    cause = FC_NONE;

        case (nBytes)
            3'd1:    begin wordAligned = {bus.wdata[7:0], 24'h0};  laneMask = 4'b1000; end
            3'd2:    begin wordAligned = {bus.wdata[15:0], 16'h0}; laneMask = 4'b1100; end
            default: begin wordAligned = bus.wdata;                laneMask = 4'b1111; end
        endcase
        wdata64 = {wordAligned, 32'h0} >> {off, 3'b000};
        be8     = bus.req_write ? ({laneMask, 4'h0} >> off) : 8'h00;

        ramEn    = 1'b0;
        ramBe    = 4'h0;
        ramIdx   = reqIdx;
        ramWdata = wdata64[63:32];
        if (state == S_SPLIT) begin
            ramEn    = 1'b1;
            ramBe    = pendBe;
            ramIdx   = pendIdx;
            ramWdata = pendData;
        end else if (accept && (cause == FC_NONE)) begin
            ramEn = 1'b1;
            ramBe = be8[7:4];
        end
    end

    dmem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .Clock (Clock),
        .en    (ramEn),
        .be    (ramBe),
        .idx   (ramIdx),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            respValid  <= 1'b0;
            faultReg   <= 1'b0;
            faultCause <= FC_NONE;
            respLoad   <= 1'b0;
            respSigned <= 1'b0;
            respSplit  <= 1'b0;
            respOff    <= 2'b00;
            respBytes  <= 3'd0;
            beat1Word  <= 32'h0;
            pendIdx    <= '0;
            pendBe     <= 4'h0;
            pendData   <= 32'h0;
        end else begin
            respValid  <= 1'b0;
            faultReg   <= 1'b0;
            faultCause <= FC_NONE;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        respLoad   <= !bus.req_write && (cause == FC_NONE);
                        respSigned <= !bus.f3[2];
                        respOff    <= off;
                        respBytes  <= nBytes;
                        respSplit  <= (cause == FC_NONE) && crossing;
                        pendIdx    <= reqIdx + 1'b1;
                        pendBe     <= be8[3:0];
                        pendData   <= wdata64[31:0];
                        if ((cause == FC_NONE) && crossing) begin
                            state <= S_SPLIT;
                        end else begin
                            respValid  <= 1'b1;
                            faultReg   <= (cause != FC_NONE);
                            faultCause <= cause;
                        end
                    end
                end
                S_SPLIT: begin
                    beat1Word <= ramRdata;
                    respValid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Realign the fetched window so the addressed bytes sit at the top, then extend.
    always_comb begin
        merged = respSplit ? {beat1Word, ramRdata} : {ramRdata, 32'h0};
        sel    = merged[6'd63 - {respOff, 3'b000} -: 32];
        case (respBytes)
            3'd1:    loadVal = respSigned ? {{24{sel[31]}}, sel[31:24]} : {24'h0, sel[31:24]};
            3'd2:    loadVal = respSigned ? {{16{sel[31]}}, sel[31:16]} : {16'h0, sel[31:16]};
            default: loadVal = sel;
        endcase
        bus.rdata = (respValid && respLoad) ? loadVal : 32'h0;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one split-enabled and one split-disabled instance driven in lockstep.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        reqValid, reqWrite;
    logic [2:0]  reqF3;
    logic [31:0] reqAddr, reqWdata;

    int total = 0;
    int bad   = 0;

    bit [7:0]    model [2][MEM_BYTES];
    logic [31:0] lastD [2];
    logic [1:0]  lastC [2];

    typedef struct {
        bit        w;
        bit [2:0]  f;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] rdS;
        bit [1:0]  fcS;
        bit [31:0] rdN;
        bit [1:0]  fcN;
    } vec_t;

    vec_t vecs [20];

    dmem_if busS();
    dmem_if busN();

    assign busS.req_valid = reqValid;
    assign busS.req_write = reqWrite;
    assign busS.f3        = reqF3;
    assign busS.addr      = reqAddr;
    assign busS.wdata     = reqWdata;
    assign busN.req_valid = reqValid;
    assign busN.req_write = reqWrite;
    assign busN.f3        = reqF3;
    assign busN.addr      = reqAddr;
    assign busN.wdata     = reqWdata;

    dmem_ctrl #(.DEPTH_WORDS(256), .MISALIGN_SPLIT(1'b1)) dutS (.Clock(Clock), .nReset(nReset), .bus(busS));
    dmem_ctrl #(.DEPTH_WORDS(256), .MISALIGN_SPLIT(1'b0)) dutN (.Clock(Clock), .nReset(nReset), .bus(busN));

    logic        respV [2];
    logic        rdy   [2];
    logic        respF [2];
    logic [31:0] respD [2];
    logic [1:0]  respC [2];

    assign respV[0] = busS.resp_valid;
    assign respV[1] = busN.resp_valid;
    assign rdy[0]   = busS.req_ready;
    assign rdy[1]   = busN.req_ready;
    assign respF[0] = busS.fault;
    assign respF[1] = busN.fault;
    assign respD[0] = busS.rdata;
    assign respD[1] = busN.rdata;
    assign respC[0] = busS.fault_cause;
    assign respC[1] = busN.fault_cause;

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Byte-addressed memory view; d=0 splits crossing accesses, d=1 faults all misalignment.
    task automatic modelTxn(input int d, input bit w, input bit [2:0] f, input bit [31:0] a,
                            input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] fc,
                            output int lat);
        int n;
        bit [31:0] v;
        rd  = 32'h0;
        fc  = 2'b00;
        lat = 1;
        case (f)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        if (n == 0 || (w && f[2]))                       fc = 2'b11;
        else if (longint'(a) + n - 1 >= MEM_BYTES)       fc = 2'b10;
        else if ((int'(a[1:0]) % n) != 0 && d == 1)      fc = 2'b01;
        if (fc == 2'b00) begin
            if (d == 0 && int'(a[1:0]) + n > 4) lat = 2;
            if (w) begin
                for (int j = 0; j < n; j++) model[d][int'(a) + j] = 8'(wd >> (8 * (n - 1 - j)));
            end else begin
                v = 32'h0;
                for (int j = 0; j < n; j++) v = (v << 8) | {24'h0, model[d][int'(a) + j]};
                if (n == 1)      v = f[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (n == 2) v = f[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit w, input bit [2:0] f,
                                 input bit [31:0] a, input bit [31:0] wd);
        bit [31:0] expD [2];
        bit [1:0]  expC [2];
        int        expLat [2];
        int        first [2];
        int        pulses [2];
        logic      gotF [2];
        int        notReady;
        string     dn [2];
        dn[0] = "split";
        dn[1] = "nosplit";
        for (int d = 0; d < 2; d++) modelTxn(d, w, f, a, wd, expD[d], expC[d], expLat[d]);
        @(negedge Clock);
        reqValid = 1'b1;
        reqWrite = w;
        reqF3    = f;
        reqAddr  = a;
        reqWdata = wd;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("%s %s ready", tag, dn[d]), 32'(rdy[d]), 32'd1);
        @(negedge Clock);
        reqValid = 1'b0;
        notReady = 0;
        for (int d = 0; d < 2; d++) begin
            first[d]  = 0;
            pulses[d] = 0;
            lastD[d]  = 32'h0;
            lastC[d]  = 2'b00;
            gotF[d]   = 1'b0;
        end
        for (int c = 1; c <= 4; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (respV[d]) begin
                    pulses[d]++;
                    if (first[d] == 0) begin
                        first[d] = c;
                        lastD[d] = respD[d];
                        lastC[d] = respC[d];
                        gotF[d]  = respF[d];
                    end
                end
            end
            if (!rdy[0]) notReady++;
            if (c < 4) @(negedge Clock);
        end
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s %s pulses", tag, dn[d]), pulses[d], 1);
            checkOutput($sformatf("%s %s latency", tag, dn[d]), first[d], expLat[d]);
            checkOutput($sformatf("%s %s fault", tag, dn[d]), 32'(gotF[d]), 32'(expC[d] != 2'b00));
            checkOutput($sformatf("%s %s cause", tag, dn[d]), 32'(lastC[d]), 32'(expC[d]));
            checkOutput($sformatf("%s %s rdata", tag, dn[d]), lastD[d], expD[d]);
        end
        checkOutput($sformatf("%s split busy cycles", tag), notReady, expLat[0] - 1);
    endtask

    initial begin
        int        respCount [2];
        bit        sawResp;
        bit [2:0]  rf;
        bit [31:0] ra;
        int        r;

        vecs[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{1'b0, 3'b100, 32'h010, 32'h0,        32'h000000DE, 2'b00, 32'h000000DE, 2'b00};
        vecs[3]  = '{1'b0, 3'b000, 32'h011, 32'h0,        32'hFFFFFFAD, 2'b00, 32'hFFFFFFAD, 2'b00};
        vecs[4]  = '{1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFFBEEF, 2'b00, 32'hFFFFBEEF, 2'b00};
        vecs[5]  = '{1'b1, 3'b010, 32'h020, 32'h0,        32'h0,        2'b00, 32'h0,        2'b00};
        vecs[6]  = '{1'b1, 3'b010, 32'h024, 32'h0,        32'h0,        2'b00, 32'h0,        2'b00};
        vecs[7]  = '{1'b1, 3'b010, 32'h022, 32'h11223344, 32'h0,        2'b00, 32'h0,        2'b01};
        vecs[8]  = '{1'b0, 3'b010, 32'h020, 32'h0,        32'h00001122, 2'b00, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 3'b010, 32'h024, 32'h0,        32'h33440000, 2'b00, 32'h0,        2'b00};
        vecs[10] = '{1'b0, 3'b010, 32'h022, 32'h0,        32'h11223344, 2'b00, 32'h0,        2'b01};
        vecs[11] = '{1'b0, 3'b001, 32'h011, 32'h0,        32'hFFFFADBE, 2'b00, 32'h0,        2'b01};
        vecs[12] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h0,        2'b00, 32'h0,        2'b00};
        vecs[13] = '{1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        2'b10, 32'h0,        2'b10};
        vecs[14] = '{1'b0, 3'b001, 32'h3FF, 32'h0,        32'h0,        2'b10, 32'h0,        2'b10};
        vecs[15] = '{1'b1, 3'b100, 32'h010, 32'h0,        32'h0,        2'b11, 32'h0,        2'b11};
        vecs[16] = '{1'b1, 3'b100, 32'h400, 32'h0,        32'h0,        2'b11, 32'h0,        2'b11};
        vecs[17] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        2'b11, 32'h0,        2'b11};
        vecs[18] = '{1'b1, 3'b010, 32'h030, 32'h01020304, 32'h0,        2'b00, 32'h0,        2'b00};
        vecs[19] = '{1'b1, 3'b010, 32'h034, 32'h05060708, 32'h0,        2'b00, 32'h0,        2'b00};

        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqF3    = 3'b000;
        reqAddr  = 32'h0;
        reqWdata = 32'h0;
        nReset   = 1'b0;
        repeat (3) @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);

        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset resp_valid %0d", d), 32'(respV[d]), 32'd0);
            checkOutput($sformatf("reset rdata %0d", d), respD[d], 32'd0);
            checkOutput($sformatf("reset fault %0d", d), 32'(respF[d]), 32'd0);
            checkOutput($sformatf("reset cause %0d", d), 32'(respC[d]), 32'd0);
            checkOutput($sformatf("reset ready %0d", d), 32'(rdy[d]), 32'd1);
        end

        // Zero the whole RAM so the model and both instances start from known contents.
        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            @(negedge Clock);
            reqValid = 1'b1;
            reqWrite = 1'b1;
            reqF3    = 3'b010;
            reqAddr  = 32'(4 * i);
            reqWdata = 32'h0;
        end
        @(negedge Clock);
        reqValid = 1'b0;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].wd);
            checkOutput($sformatf("vec%0d split table rdata", i), lastD[0], vecs[i].rdS);
            checkOutput($sformatf("vec%0d split table cause", i), 32'(lastC[0]), 32'(vecs[i].fcS));
            checkOutput($sformatf("vec%0d nosplit table rdata", i), lastD[1], vecs[i].rdN);
            checkOutput($sformatf("vec%0d nosplit table cause", i), 32'(lastC[1]), 32'(vecs[i].fcN));
        end

        // Reset lands while the split store is between its two beats.
        @(negedge Clock);
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqF3    = 3'b010;
        reqAddr  = 32'h31;
        reqWdata = 32'hAABBCCDD;
        @(negedge Clock);
        reqValid = 1'b0;
        checkOutput("rst-split busy", 32'(rdy[0]), 32'd0);
        nReset  = 1'b0;
        sawResp = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            if (respV[0]) sawResp = 1'b1;
        end
        nReset = 1'b1;
        @(negedge Clock);
        if (respV[0]) sawResp = 1'b1;
        checkOutput("rst-split no response", 32'(sawResp), 32'd0);
        checkOutput("rst-split ready after", 32'(rdy[0]), 32'd1);
        model[0][32'h31] = 8'hAA;
        model[0][32'h32] = 8'hBB;
        model[0][32'h33] = 8'hCC;
        applyStimulus("rst-split lw30", 1'b0, 3'b010, 32'h30, 32'h0);
        checkOutput("rst-split word30 split", lastD[0], 32'h01AABBCC);
        checkOutput("rst-split word30 nosplit", lastD[1], 32'h01020304);
        applyStimulus("rst-split lw34", 1'b0, 3'b010, 32'h34, 32'h0);
        checkOutput("rst-split word34", lastD[0], 32'h05060708);

        // Alternating SB/LBU with req_valid held high.
        respCount[0] = 0;
        respCount[1] = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            for (int d = 0; d < 2; d++) begin
                if (respV[d]) respCount[d]++;
                if (i >= 1 && i <= 8) begin
                    checkOutput($sformatf("b2b%0d valid %0d", i, d), 32'(respV[d]), 32'd1);
                    if (((i - 1) % 2) == 1)
                        checkOutput($sformatf("b2b%0d lbu %0d", i, d), respD[d], 32'h0000005A);
                end
            end
            if (i < 8) begin
                reqValid = 1'b1;
                reqWrite = ((i % 2) == 0);
                reqF3    = ((i % 2) == 0) ? 3'b000 : 3'b100;
                reqAddr  = 32'h40;
                reqWdata = 32'h1234565A;
                checkOutput($sformatf("b2b%0d ready", i), 32'(rdy[0]), 32'd1);
            end else begin
                reqValid = 1'b0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("b2b count %0d", d), respCount[d], 8);
            model[d][32'h40] = 8'h5A;
        end

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            rf = 3'($urandom_range(0, 7));
            if (r < 7)      ra = 32'($urandom_range(0, MEM_BYTES - 1));
            else if (r < 9) ra = 32'(MEM_BYTES - 4 + $urandom_range(0, 5));
            else            ra = $urandom;
            applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rf, ra, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, handshaked data-memory controller for the pipeline's MEM stage, replacing the fixed 1 KiB byte array. It serves RV32 loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a req/resp interface with big-endian byte order. It detects illegal, out-of-range and misaligned accesses, and optionally splits word-crossing misaligned accesses into two beats.

Parameters:
DEPTH_WORDS, 256, memory size in 32-bit words (bytes = 4*DEPTH_WORDS); power of two, ≥4
MISALIGN_SPLIT, 1, 1 = word-crossing misaligned accesses performed in two beats; 0 = all misaligned accesses fault

Ports:
Clock  in  1  single clock, rising edge
nReset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1 = store, 0 = load
f3  in  3  RV32 funct3 (size/sign)
addr  in  32  byte address
wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
rdata  out  32  load result (sign/zero-extended); 0 when not a valid load response
fault  out  1  qualifies resp_valid; access aborted
fault_cause  out  2  01 misaligned, 10 out of range, 11 illegal f3; 00 when fault=0

Behaviour:
- Reset (async, nReset=0): FSM→IDLE; resp_valid=0, rdata=0, fault=0, fault_cause=00. RAM contents not reset.
- Accept = req_valid & req_ready. req_ready=1 only in IDLE. Every accepted request produces exactly one resp_valid pulse.
- Byte order is big-endian. Byte at word offset k occupies lane bits [31-8k -: 8]. SH/SW store MSB at the lowest address.
- Priority of checks at accept: illegal (f3 ∈ {011,110,111}, or store with f3 ∈ {100,101}) > out of range (addr+size-1 ≥ 4*DEPTH_WORDS, full 32-bit compare, no wrap) > misaligned.
- Faulted request: no RAM write. resp_valid=1, fault=1, rdata=0 in the cycle after accept.
- Misaligned = half at odd addr, or word with addr[1:0]≠0.
- Word-contained misaligned (LH/SH at addr[1:0]=01): faults if MISALIGN_SPLIT=0. Otherwise executes as aligned.
- Crossing = word with addr[1:0]≠0, or half with addr[1:0]=11. Faults if MISALIGN_SPLIT=0. Otherwise split.
- States:
  IDLE: accept. Single-beat: RAM access on the accept edge, then → IDLE with resp_valid=1 on the next cycle (latency 1). Crossing: beat 1 (lower word) on the accept edge, then → SPLIT.
  SPLIT: req_ready=0. Beat 2 (word index+1) on this edge. Response in the following cycle (latency 2). Then → IDLE.
- Stores: per-byte write enables. Unselected lanes are unchanged. resp_valid=1, rdata=0.
- Loads: the registered read merges beat-1/beat-2 bytes. LB/LH sign-extend; LBU/LHU zero-extend.
- Back-to-back: one single-beat request per cycle sustained. A load accepted the cycle after a store to the same bytes returns the new data.
- Reset during SPLIT: beat 1 is already committed, beat 2 is not performed, no response. The split store is documented as non-atomic under reset.
- resp_valid, fault and rdata are registered outputs. They are never combinational from req_*.

Decomposition:
- Package dmem_pkg:
  - f3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - fault_cause_t enum {FC_NONE, FC_MISALIGN, FC_RANGE, FC_ILLEGAL}
  - state_t enum {S_IDLE, S_SPLIT}
- Sub-module dmem_word_ram: DEPTH_WORDS×32 array, 4-bit byte write enable, synchronous read port; one access per cycle.
- Lane shift, merge and extension logic stays in dmem_ctrl.

Test Plan:
- SW 0xDEADBEEF @0x10; LW @0x10 → rdata 0xDEADBEEF one cycle after accept; LBU @0x10 → 0x000000DE; LB @0x11 → 0xFFFFFFAD; LH @0x12 → 0xFFFFBEEF.
- SPLIT=1:
  - Setup: SW 0 @0x20 and SW 0 @0x24.
  - SW 0x11223344 @0x22 → req_ready=0 for exactly one cycle.
  - LW @0x20 → 0x00001122; LW @0x24 → 0x33440000.
  - LW @0x22 → 0x11223344 two cycles after accept.
- SPLIT=0: LW @0x22 → fault=1, cause 01, rdata 0. Subsequent LW @0x20 shows RAM unchanged. LH @0x11 → cause 01.
- DEPTH_WORDS=256:
  - LW @0x3FC → ok.
  - LW @0x400 → cause 10.
  - LH @0x3FF → cause 10.
  - SW with f3=100 → cause 11 (illegal beats range: same result @0x400).
- Drive nReset low during SPLIT of SW 0xAABBCCDD @0x31 → resp_valid never pulses. After release req_ready=1; LW @0x30 → 0x??AABBCC (first word written, byte 0x30 unchanged); LW @0x34 unchanged.
- req_valid held 8 cycles alternating SB 0x5A @0x40 / LBU @0x40 → 8 responses on consecutive cycles; every LBU returns 0x0000005A.
